// File: rtl/secuenciador_alu.sv
//------------------------------------------------------------------------------
// Module      : secuenciador_alu
// Description : Operand/opcode sequencer for an external combinational ALU.
//               Loads operand A, then operand B plus the operation code on
//               successive button presses, waits ESPERA cycles for the ALU to
//               settle, captures result and flags, and presents them until the
//               consumer acknowledges.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module secuenciador_alu #(
    parameter int ANCHO  = 3,
    parameter int ESPERA = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO:0]   dato,
    input  logic [3:0]       codigo,
    input  logic             cargar,
    input  logic             listo_ack,
    input  logic [ANCHO:0]   resultadoALU,
    input  logic [3:0]       banderasALU,
    output logic [ANCHO:0]   operandoA,
    output logic [ANCHO:0]   operandoB,
    output logic [3:0]       seleccion,
    output logic [ANCHO:0]   resultado,
    output logic [3:0]       banderas,
    output logic             valido,
    output logic             error,
    output logic [1:0]       estado
);

    localparam logic [1:0] ST_ESPERA_A  = 2'b00;
    localparam logic [1:0] ST_ESPERA_B  = 2'b01;
    localparam logic [1:0] ST_CALCULO   = 2'b10;
    localparam logic [1:0] ST_RESULTADO = 2'b11;

    // Counter preload: capture happens ESPERA edges after the B-load edge.
    localparam logic [3:0] C_CARGA_CONTADOR = 4'(ESPERA - 1);
    localparam logic [3:0] C_CODIGO_MAX     = 4'd9;
    localparam logic [3:0] C_BANDERAS_ERROR = 4'b0100;

    logic [1:0]     r_estado;
    logic           r_cargar_prev;
    logic [3:0]     r_contador;
    logic [ANCHO:0] r_operando_a;
    logic [ANCHO:0] r_operando_b;
    logic [3:0]     r_seleccion;
    logic [ANCHO:0] r_resultado;
    logic [3:0]     r_banderas;
    logic           r_valido;
    logic           r_error;

    logic           w_evento;
    logic           w_codigo_valido;

    // One load event per press: level high now, low on the previous edge.
    assign w_evento        = cargar & ~r_cargar_prev;
    assign w_codigo_valido = (r_seleccion <= C_CODIGO_MAX);

    // Previous button sample; reset to 1 so a press held through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cargar_prev <= 1'b1;
        end else begin
            r_cargar_prev <= cargar;
        end
    end

    // Sequencer FSM with operand, opcode and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= ST_ESPERA_A;
            r_contador   <= 4'd0;
            r_operando_a <= '0;
            r_operando_b <= '0;
            r_seleccion  <= 4'd0;
            r_resultado  <= '0;
            r_banderas   <= 4'd0;
            r_valido     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_estado)
                ST_ESPERA_A: begin
                    if (w_evento) begin
                        r_operando_a <= dato;
                        r_estado     <= ST_ESPERA_B;
                    end
                end
                ST_ESPERA_B: begin
                    if (w_evento) begin
                        r_operando_b <= dato;
                        r_seleccion  <= codigo;
                        r_contador   <= C_CARGA_CONTADOR;
                        r_estado     <= ST_CALCULO;
                    end
                end
                ST_CALCULO: begin
                    if (r_contador == 4'd0) begin
                        // Invalid opcodes never trust the ALU outputs.
                        if (w_codigo_valido) begin
                            r_resultado <= resultadoALU;
                            r_banderas  <= banderasALU;
                            r_error     <= 1'b0;
                        end else begin
                            r_resultado <= '0;
                            r_banderas  <= C_BANDERAS_ERROR;
                            r_error     <= 1'b1;
                        end
                        r_valido <= 1'b1;
                        r_estado <= ST_RESULTADO;
                    end else begin
                        r_contador <= r_contador - 4'd1;
                    end
                end
                ST_RESULTADO: begin
                    // Ack wins over any simultaneous press; the press is dropped.
                    if (listo_ack) begin
                        r_valido <= 1'b0;
                        r_estado <= ST_ESPERA_A;
                    end
                end
                default: begin
                    r_estado <= ST_ESPERA_A;
                end
            endcase
        end
    end

    assign operandoA = r_operando_a;
    assign operandoB = r_operando_b;
    assign seleccion = r_seleccion;
    assign resultado = r_resultado;
    assign banderas  = r_banderas;
    assign valido    = r_valido;
    assign error     = r_error;
    assign estado    = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_alu.sv
//------------------------------------------------------------------------------
// Module      : tb_secuenciador_alu
// Description : Self-checking bench for secuenciador_alu with a modelled ALU,
//               directed vector table, hand-written reset sequences and a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_secuenciador_alu;

    localparam int ANCHO  = 3;
    localparam int ESPERA = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [ANCHO:0] dato;
    logic [3:0]     codigo;
    logic           cargar;
    logic           listo_ack;
    logic [ANCHO:0] resultadoALU;
    logic [3:0]     banderasALU;
    logic [ANCHO:0] operandoA;
    logic [ANCHO:0] operandoB;
    logic [3:0]     seleccion;
    logic [ANCHO:0] resultado;
    logic [3:0]     banderas;
    logic           valido;
    logic           error;
    logic [1:0]     estado;

    int checks = 0;
    int errors = 0;

    secuenciador_alu #(.ANCHO(ANCHO), .ESPERA(ESPERA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dato         (dato),
        .codigo       (codigo),
        .cargar       (cargar),
        .listo_ack    (listo_ack),
        .resultadoALU (resultadoALU),
        .banderasALU  (banderasALU),
        .operandoA    (operandoA),
        .operandoB    (operandoB),
        .seleccion    (seleccion),
        .resultado    (resultado),
        .banderas     (banderas),
        .valido       (valido),
        .error        (error),
        .estado       (estado)
    );

    always #5 clk = ~clk;

    // 4-bit ALU: returns {N,Z,C,V, result}. Invalid codes return F / 1111.
    function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        logic [4:0] t;
        logic [3:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (s)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4];
                        v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[3:0]; c = ~t[4];
                        v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            4'd7: begin r = {1'b0, a[3:1]}; c = a[0]; end
            4'd8: r = a;
            4'd9: r = b;
            default: return 8'hFF;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    always_comb begin
        {banderasALU, resultadoALU} = alu(operandoA, operandoB, seleccion);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Table of directed vectors: inputs for one edge, outputs after it.
    typedef struct {
        logic       c;
        logic [3:0] d;
        logic [3:0] cod;
        logic       ack;
        logic [1:0] est;
        logic       val;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic [3:0] res;
        logic [3:0] flg;
        logic       err;
    } vec_t;

    vec_t tabla[$];

    task automatic add(input logic c, input logic [3:0] d, input logic [3:0] cod, input logic ack,
                       input logic [1:0] est, input logic val, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sel, input logic [3:0] res, input logic [3:0] flg, input logic err);
        vec_t v;
        v = '{c, d, cod, ack, est, val, a, b, sel, res, flg, err};
        tabla.push_back(v);
    endtask

    // Reference model state (transaction level).
    int         m_fase;      // 0 wait A, 1 wait B, 2 computing, 3 presenting
    int         m_ciclos;    // edges spent computing so far
    logic       m_prev;
    logic [3:0] mA, mB, mS, mR, mF;
    logic       mE;

    function automatic void modelo_reset();
        m_fase = 0; m_ciclos = 0; m_prev = 1'b1;
        mA = 0; mB = 0; mS = 0; mR = 0; mF = 0; mE = 0;
    endfunction

    function automatic void modelo_paso(input logic c, input logic [3:0] d, input logic [3:0] cod, input logic ack);
        logic ev;
        ev = c && !m_prev;
        m_prev = c;
        case (m_fase)
            0: if (ev) begin mA = d; m_fase = 1; end
            1: if (ev) begin mB = d; mS = cod; m_ciclos = 0; m_fase = 2; end
            2: begin
                m_ciclos++;
                if (m_ciclos == ESPERA) begin
                    if (mS <= 9) begin {mF, mR} = alu(mA, mB, mS); mE = 0; end
                    else begin mR = 0; mF = 4'b0100; mE = 1; end
                    m_fase = 3;
                end
            end
            default: if (ack) m_fase = 0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cargar = 1'b0; listo_ack = 1'b0; dato = 0; codigo = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); // idle edge with cargar low so the next press counts
        modelo_reset();
        m_prev = 1'b0;
        #1;
    endtask

    task automatic chk_todo_cero(input string nm);
        chk({nm, "_estado"}, 32'(estado), 0);
        chk({nm, "_valido"}, 32'(valido), 0);
        chk({nm, "_error"}, 32'(error), 0);
        chk({nm, "_resultado"}, 32'(resultado), 0);
        chk({nm, "_banderas"}, 32'(banderas), 0);
        chk({nm, "_opA"}, 32'(operandoA), 0);
        chk({nm, "_opB"}, 32'(operandoB), 0);
        chk({nm, "_sel"}, 32'(seleccion), 0);
    endtask

    initial begin
        rst_n = 1'b1; cargar = 1'b0; listo_ack = 1'b0; dato = 0; codigo = 0;
        modelo_reset();

        // Reset asserted mid-cycle takes effect before the next edge.
        #2 rst_n = 1'b0;
        #1 chk_todo_cero("reset_async");
        do_reset();
        chk_todo_cero("after_reset");

        // Directed table.
        add(1,5,0,0,  1,0,5,0,0,0,0,0);
        add(0,5,0,0,  1,0,5,0,0,0,0,0);
        add(1,3,0,0,  2,0,5,3,0,0,0,0);
        add(0,0,0,0,  3,1,5,3,0,8,9,0);
        add(0,0,0,0,  3,1,5,3,0,8,9,0);
        add(0,0,0,1,  0,0,5,3,0,8,9,0);
        add(1,2,5,0,  1,0,2,3,0,8,9,0);
        add(0,2,5,1,  1,0,2,3,0,8,9,0);
        add(1,1,12,0, 2,0,2,1,12,8,9,0);
        add(0,1,0,0,  3,1,2,1,12,0,4,1);
        add(1,6,0,0,  3,1,2,1,12,0,4,1);
        add(0,6,0,0,  3,1,2,1,12,0,4,1);
        add(1,9,0,1,  0,0,2,1,12,0,4,1);
        add(1,9,0,0,  0,0,2,1,12,0,4,1);
        add(0,9,0,1,  0,0,2,1,12,0,4,1);
        for (int i = 0; i < 10; i++) add(1,7,0,0, 1,0,7,1,12,0,4,1);

        for (int i = 0; i < tabla.size(); i++) begin
            @(negedge clk);
            cargar = tabla[i].c; dato = tabla[i].d; codigo = tabla[i].cod; listo_ack = tabla[i].ack;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_estado", i),    32'(estado),    32'(tabla[i].est));
            chk($sformatf("vec%0d_valido", i),    32'(valido),    32'(tabla[i].val));
            chk($sformatf("vec%0d_opA", i),       32'(operandoA), 32'(tabla[i].a));
            chk($sformatf("vec%0d_opB", i),       32'(operandoB), 32'(tabla[i].b));
            chk($sformatf("vec%0d_sel", i),       32'(seleccion), 32'(tabla[i].sel));
            chk($sformatf("vec%0d_resultado", i), 32'(resultado), 32'(tabla[i].res));
            chk($sformatf("vec%0d_banderas", i),  32'(banderas),  32'(tabla[i].flg));
            chk($sformatf("vec%0d_error", i),     32'(error),     32'(tabla[i].err));
        end

        // Abort: reset while computing, no capture afterwards.
        do_reset();
        @(negedge clk); cargar = 1; dato = 4'd5;
        @(negedge clk); cargar = 0;
        @(negedge clk); cargar = 1; dato = 4'd3; codigo = 4'd0;
        @(posedge clk); #1;
        chk("abort_in_calc", 32'(estado), 2);
        rst_n = 1'b0;
        #1 chk_todo_cero("abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valido", 32'(valido), 0);
        end

        // Button held through reset release generates no event.
        @(negedge clk); cargar = 1; dato = 4'd6; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("held_reset_estado", 32'(estado), 0);
        @(negedge clk); cargar = 0;
        @(negedge clk); cargar = 1;
        @(posedge clk); #1;
        chk("press_after_release_estado", 32'(estado), 1);
        chk("press_after_release_opA", 32'(operandoA), 6);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cargar    = ($urandom_range(0, 1) == 1);
            listo_ack = ($urandom_range(0, 2) == 0);
            dato      = 4'($urandom_range(0, 15));
            codigo    = 4'($urandom_range(0, 15));
            @(posedge clk);
            modelo_paso(cargar, dato, codigo, listo_ack);
            #1;
            chk("rnd_estado",    32'(estado),    32'(m_fase));
            chk("rnd_valido",    32'(valido),    32'(m_fase == 3));
            chk("rnd_opA",       32'(operandoA), 32'(mA));
            chk("rnd_opB",       32'(operandoB), 32'(mB));
            chk("rnd_sel",       32'(seleccion), 32'(mS));
            chk("rnd_resultado", 32'(resultado), 32'(mR));
            chk("rnd_banderas",  32'(banderas),  32'(mF));
            chk("rnd_error",     32'(error),     32'(mE));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
